// File: rtl/dma_address_count_bank.sv
// Address/word-count register bank for a KF8237-family DMA controller: byte-serial
// programming through a shared pointer, per-channel hold/decrement/autoinit and a TC pulse.
module dma_address_count_bank #(
    parameter int CHANNELS    = 4,
    parameter int ADDR_WIDTH  = 24,
    parameter int COUNT_WIDTH = 16,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    input  logic [CHANNELS-1:0]    write_address,
    input  logic [CHANNELS-1:0]    write_count,
    input  logic [CHANNELS-1:0]    read_address,
    input  logic [CHANNELS-1:0]    read_count,
    input  logic                   clear_byte_pointer,
    input  logic                   master_clear,
    input  logic [CHANNELS-1:0]    channel_select,
    input  logic                   initialize,
    input  logic                   next_word,
    input  logic [CHANNELS-1:0]    hold_config,
    input  logic [CHANNELS-1:0]    decrement_config,
    input  logic [CHANNELS-1:0]    autoinit_config,
    output logic [ADDR_WIDTH-1:0]  transfer_address,
    output logic                   update_high_address,
    output logic [CHANNELS-1:0]    terminal_count
);

    localparam int ABYTES   = (ADDR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int CBYTES   = (COUNT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int MAXBYTES = (ABYTES > CBYTES) ? ABYTES : CBYTES;
    localparam int PTR_W    = (MAXBYTES > 1) ? $clog2(MAXBYTES) : 1;
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW_PAD   = ABYTES * DATA_WIDTH;
    localparam int CW_PAD   = CBYTES * DATA_WIDTH;

    logic [ADDR_WIDTH-1:0]  base_addr_q [CHANNELS];
    logic [ADDR_WIDTH-1:0]  base_addr_d [CHANNELS];
    logic [ADDR_WIDTH-1:0]  cur_addr_q  [CHANNELS];
    logic [ADDR_WIDTH-1:0]  cur_addr_d  [CHANNELS];
    logic [COUNT_WIDTH-1:0] base_cnt_q  [CHANNELS];
    logic [COUNT_WIDTH-1:0] base_cnt_d  [CHANNELS];
    logic [COUNT_WIDTH-1:0] cur_cnt_q   [CHANNELS];
    logic [COUNT_WIDTH-1:0] cur_cnt_d   [CHANNELS];
    logic [ADDR_WIDTH-1:0]  step_addr   [CHANNELS];
    logic [COUNT_WIDTH-1:0] step_cnt    [CHANNELS];

    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   rd_addr_prev_q, rd_addr_prev_d;
    logic                   rd_cnt_prev_q, rd_cnt_prev_d;
    logic [ADDR_WIDTH-1:0]  transfer_address_q, transfer_address_d;
    logic [CHANNELS-1:0]    terminal_count_q, terminal_count_d;
    logic [SEL_W-1:0]       sel_idx;
    logic                   sel_valid;

    function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p, input int nbytes);
        if (int'(p) >= nbytes - 1) return '0;
        return p + PTR_W'(1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] put_addr_byte(input logic [ADDR_WIDTH-1:0] v,
                                                            input logic [PTR_W-1:0] p,
                                                            input logic [DATA_WIDTH-1:0] b);
        logic [AW_PAD-1:0] pad;
        pad = AW_PAD'(v);
        for (int i = 0; i < ABYTES; i++)
            if (int'(p) == i) pad[i*DATA_WIDTH +: DATA_WIDTH] = b;
        return pad[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] put_cnt_byte(input logic [COUNT_WIDTH-1:0] v,
                                                            input logic [PTR_W-1:0] p,
                                                            input logic [DATA_WIDTH-1:0] b);
        logic [CW_PAD-1:0] pad;
        pad = CW_PAD'(v);
        for (int i = 0; i < CBYTES; i++)
            if (int'(p) == i) pad[i*DATA_WIDTH +: DATA_WIDTH] = b;
        return pad[COUNT_WIDTH-1:0];
    endfunction

    // Pointer positions past the register's last byte read as zero.
    function automatic logic [DATA_WIDTH-1:0] get_addr_byte(input logic [ADDR_WIDTH-1:0] v,
                                                            input logic [PTR_W-1:0] p);
        logic [AW_PAD-1:0]     pad;
        logic [DATA_WIDTH-1:0] r;
        pad = AW_PAD'(v);
        r   = '0;
        for (int i = 0; i < ABYTES; i++)
            if (int'(p) == i) r = pad[i*DATA_WIDTH +: DATA_WIDTH];
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] get_cnt_byte(input logic [COUNT_WIDTH-1:0] v,
                                                           input logic [PTR_W-1:0] p);
        logic [CW_PAD-1:0]     pad;
        logic [DATA_WIDTH-1:0] r;
        pad = CW_PAD'(v);
        r   = '0;
        for (int i = 0; i < CBYTES; i++)
            if (int'(p) == i) r = pad[i*DATA_WIDTH +: DATA_WIDTH];
        return r;
    endfunction

    always_comb begin
        sel_idx   = '0;
        sel_valid = |channel_select;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (channel_select[i]) sel_idx = SEL_W'(i);
    end

    // Value each channel would take on next_word; an underflow with autoinit reloads from base.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (autoinit_config[ch] && cur_cnt_q[ch] == '0) begin
                step_addr[ch] = base_addr_q[ch];
                step_cnt[ch]  = base_cnt_q[ch];
            end else begin
                if (hold_config[ch])
                    step_addr[ch] = cur_addr_q[ch];
                else if (decrement_config[ch])
                    step_addr[ch] = cur_addr_q[ch] - ADDR_WIDTH'(1);
                else
                    step_addr[ch] = cur_addr_q[ch] + ADDR_WIDTH'(1);
                step_cnt[ch] = cur_cnt_q[ch] - COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        logic hit;
        logic rd_addr_fall;
        logic rd_cnt_fall;

        rd_addr_prev_d     = |read_address;
        rd_cnt_prev_d      = |read_count;
        rd_addr_fall       = rd_addr_prev_q && !(|read_address);
        rd_cnt_fall        = rd_cnt_prev_q && !(|read_count);
        transfer_address_d = sel_valid ? cur_addr_q[sel_idx] : transfer_address_q;
        terminal_count_d   = '0;

        ptr_d = ptr_q;
        if (clear_byte_pointer)
            ptr_d = '0;
        else if (|write_address)
            ptr_d = advance(ptr_q, ABYTES);
        else if (|write_count)
            ptr_d = advance(ptr_q, CBYTES);
        else if (rd_addr_fall)
            ptr_d = advance(ptr_q, ABYTES);
        else if (rd_cnt_fall)
            ptr_d = advance(ptr_q, CBYTES);

        for (int ch = 0; ch < CHANNELS; ch++) begin
            hit             = sel_valid && (int'(sel_idx) == ch);
            base_addr_d[ch] = base_addr_q[ch];
            cur_addr_d[ch]  = cur_addr_q[ch];
            base_cnt_d[ch]  = base_cnt_q[ch];
            cur_cnt_d[ch]   = cur_cnt_q[ch];

            if (write_address[ch]) begin
                base_addr_d[ch] = put_addr_byte(base_addr_q[ch], ptr_q, data_in);
                cur_addr_d[ch]  = put_addr_byte(cur_addr_q[ch], ptr_q, data_in);
            end else if (hit && initialize) begin
                cur_addr_d[ch] = base_addr_q[ch];
            end else if (hit && next_word) begin
                cur_addr_d[ch] = step_addr[ch];
            end

            // A count write in the same cycle swallows the advance and its TC.
            if (write_count[ch]) begin
                base_cnt_d[ch] = put_cnt_byte(base_cnt_q[ch], ptr_q, data_in);
                cur_cnt_d[ch]  = put_cnt_byte(cur_cnt_q[ch], ptr_q, data_in);
            end else if (hit && initialize) begin
                cur_cnt_d[ch] = base_cnt_q[ch];
            end else if (hit && next_word) begin
                cur_cnt_d[ch]        = step_cnt[ch];
                terminal_count_d[ch] = (cur_cnt_q[ch] == '0);
            end
        end

        if (master_clear) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                base_addr_d[ch] = '0;
                cur_addr_d[ch]  = '0;
                base_cnt_d[ch]  = '0;
                cur_cnt_d[ch]   = '0;
            end
            ptr_d              = '0;
            rd_addr_prev_d     = 1'b0;
            rd_cnt_prev_d      = 1'b0;
            transfer_address_d = '0;
            terminal_count_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                base_addr_q[ch] <= '0;
                cur_addr_q[ch]  <= '0;
                base_cnt_q[ch]  <= '0;
                cur_cnt_q[ch]   <= '0;
            end
            ptr_q              <= '0;
            rd_addr_prev_q     <= 1'b0;
            rd_cnt_prev_q      <= 1'b0;
            transfer_address_q <= '0;
            terminal_count_q   <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                base_addr_q[ch] <= base_addr_d[ch];
                cur_addr_q[ch]  <= cur_addr_d[ch];
                base_cnt_q[ch]  <= base_cnt_d[ch];
                cur_cnt_q[ch]   <= cur_cnt_d[ch];
            end
            ptr_q              <= ptr_d;
            rd_addr_prev_q     <= rd_addr_prev_d;
            rd_cnt_prev_q      <= rd_cnt_prev_d;
            transfer_address_q <= transfer_address_d;
            terminal_count_q   <= terminal_count_d;
        end
    end

    always_comb begin
        logic found;
        data_out = '0;
        found    = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (!found && read_address[ch]) begin
                data_out = get_addr_byte(cur_addr_q[ch], ptr_q);
                found    = 1'b1;
            end
        end
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (!found && read_count[ch]) begin
                data_out = get_cnt_byte(cur_cnt_q[ch], ptr_q);
                found    = 1'b1;
            end
        end
    end

    generate
        if (ADDR_WIDTH > 8) begin : g_high
            logic [ADDR_WIDTH-1:0] next_sel;
            assign next_sel = sel_valid ? step_addr[sel_idx] : transfer_address_q;
            assign update_high_address = (next_sel[ADDR_WIDTH-1:8] != transfer_address_q[ADDR_WIDTH-1:8]);
        end else begin : g_no_high
            assign update_high_address = 1'b0;
        end
    endgenerate

    assign transfer_address = transfer_address_q;
    assign terminal_count   = terminal_count_q;

endmodule

// File: tb/tb_dma_address_count_bank.sv
// Directed bench for dma_address_count_bank with default parameters (4 ch, 24-bit addr, 16-bit count).
module tb_dma_address_count_bank;

  logic        clock;
  logic        reset;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [3:0]  write_address;
  logic [3:0]  write_count;
  logic [3:0]  read_address;
  logic [3:0]  read_count;
  logic        clear_byte_pointer;
  logic        master_clear;
  logic [3:0]  channel_select;
  logic        initialize;
  logic        next_word;
  logic [3:0]  hold_config;
  logic [3:0]  decrement_config;
  logic [3:0]  autoinit_config;
  logic [23:0] transfer_address;
  logic        update_high_address;
  logic [3:0]  terminal_count;

  int n_checks = 0;
  int n_errors = 0;

  dma_address_count_bank dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_out(data_out),
    .write_address(write_address), .write_count(write_count),
    .read_address(read_address), .read_count(read_count),
    .clear_byte_pointer(clear_byte_pointer), .master_clear(master_clear),
    .channel_select(channel_select), .initialize(initialize), .next_word(next_word),
    .hold_config(hold_config), .decrement_config(decrement_config),
    .autoinit_config(autoinit_config), .transfer_address(transfer_address),
    .update_high_address(update_high_address), .terminal_count(terminal_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: every input change happens 1 time unit after a rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic program_addr(input int ch, input logic [23:0] a);
    logic [23:0] v;
    v = a;
    for (int b = 0; b < 3; b++) begin
      write_address = 4'b0001 << ch;
      data_in = v[b*8 +: 8];
      step();
      write_address = '0;
    end
  endtask

  task automatic program_count(input int ch, input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int b = 0; b < 2; b++) begin
      write_count = 4'b0001 << ch;
      data_in = v[b*8 +: 8];
      step();
      write_count = '0;
    end
  endtask

  task automatic read_addr(input int ch, output logic [23:0] v);
    v = '0;
    for (int b = 0; b < 3; b++) begin
      read_address = 4'b0001 << ch;
      #2;
      v[b*8 +: 8] = data_out;
      step();
      read_address = '0;
      step();
    end
  endtask

  task automatic read_cnt(input int ch, output logic [15:0] v);
    v = '0;
    for (int b = 0; b < 2; b++) begin
      read_count = 4'b0001 << ch;
      #2;
      v[b*8 +: 8] = data_out;
      step();
      read_count = '0;
      step();
    end
  endtask

  task automatic pulse_next_word();
    next_word = 1'b1;
    step();
    next_word = 1'b0;
  endtask

  logic [23:0] a;
  logic [15:0] c;

  initial begin
    reset = 1'b1;
    data_in = '0; write_address = '0; write_count = '0; read_address = '0; read_count = '0;
    clear_byte_pointer = 1'b0; master_clear = 1'b0; channel_select = '0;
    initialize = 1'b0; next_word = 1'b0;
    hold_config = '0; decrement_config = '0; autoinit_config = '0;

    // reset state
    #12;
    check_value("rst_transfer_address", 32'(transfer_address), 32'h0);
    check_value("rst_terminal_count", 32'(terminal_count), 32'h0);
    check_value("rst_data_out", 32'(data_out), 32'h0);
    check_value("rst_update_high", 32'(update_high_address), 32'h0);
    reset = 1'b0;
    step();

    // 1: program and read back ch2
    program_addr(2, 24'h051234);
    program_count(2, 16'h0002);
    read_addr(2, a);
    check_value("t1_addr_b0", 32'(a[7:0]), 32'h34);
    check_value("t1_addr_b1", 32'(a[15:8]), 32'h12);
    check_value("t1_addr_b2", 32'(a[23:16]), 32'h05);
    read_cnt(2, c);
    check_value("t1_cnt_b0", 32'(c[7:0]), 32'h02);
    check_value("t1_cnt_b1", 32'(c[15:8]), 32'h00);
    read_addr(2, a);
    check_value("t1_ptr_wrapped", 32'(a), 32'h051234);

    // 2: increment carries into the page bits
    program_addr(2, 24'h05FFFF);
    channel_select = 4'b0100;
    step(); step();
    check_value("t2_transfer_pre", 32'(transfer_address), 32'h05FFFF);
    next_word = 1'b1;
    #2;
    check_value("t2_update_high", 32'(update_high_address), 32'h1);
    step();
    next_word = 1'b0;
    check_value("t2_no_tc", 32'(terminal_count), 32'h0);
    step();
    check_value("t2_transfer_post", 32'(transfer_address), 32'h060000);
    check_value("t2_update_high_idle", 32'(update_high_address), 32'h0);
    read_addr(2, a);
    check_value("t2_cur_addr", 32'(a), 32'h060000);
    hold_config = 4'b0100;
    pulse_next_word();
    hold_config = '0;
    read_addr(2, a);
    check_value("t2_hold_addr", 32'(a), 32'h060000);

    // 3: count underflow without autoinit
    program_count(1, 16'h0001);
    channel_select = 4'b0010;
    step();
    pulse_next_word();
    check_value("t3_no_tc_first", 32'(terminal_count), 32'h0);
    read_cnt(1, c);
    check_value("t3_cnt_zero", 32'(c), 32'h0000);
    pulse_next_word();
    check_value("t3_tc_pulse", 32'(terminal_count), 32'h2);
    step();
    check_value("t3_tc_one_cycle", 32'(terminal_count), 32'h0);
    read_cnt(1, c);
    check_value("t3_cnt_wrap", 32'(c), 32'hFFFF);

    // 4: autoinit reload on underflow, decrementing channel
    program_addr(0, 24'h001000);
    program_count(0, 16'h0000);
    autoinit_config = 4'b0001;
    decrement_config = 4'b0001;
    channel_select = 4'b0001;
    step();
    pulse_next_word();
    check_value("t4_tc_pulse", 32'(terminal_count), 32'h1);
    step();
    check_value("t4_tc_one_cycle", 32'(terminal_count), 32'h0);
    read_addr(0, a);
    check_value("t4_addr_reload", 32'(a), 32'h001000);
    read_cnt(0, c);
    check_value("t4_cnt_reload", 32'(c), 32'h0000);
    autoinit_config = '0;
    program_count(0, 16'h0005);
    pulse_next_word();
    read_addr(0, a);
    check_value("t4_addr_decrement", 32'(a), 32'h000FFF);
    read_cnt(0, c);
    check_value("t4_cnt_decrement", 32'(c), 32'h0004);
    decrement_config = '0;

    // 5: write beats next_word on the same count register
    channel_select = 4'b1000;
    step();
    write_count = 4'b1000;
    data_in = 8'h77;
    next_word = 1'b1;
    step();
    write_count = '0;
    next_word = 1'b0;
    check_value("t5_no_tc", 32'(terminal_count), 32'h0);
    clear_byte_pointer = 1'b1;
    step();
    clear_byte_pointer = 1'b0;
    read_cnt(3, c);
    check_value("t5_cnt_written", 32'(c), 32'h0077);

    // 5b: master_clear with clear_byte_pointer mid-sequence
    channel_select = '0;
    write_address = 4'b1000;
    data_in = 8'h99;
    step();
    write_address = '0;
    master_clear = 1'b1;
    clear_byte_pointer = 1'b1;
    step();
    master_clear = 1'b0;
    clear_byte_pointer = 1'b0;
    check_value("t5_mc_transfer", 32'(transfer_address), 32'h0);
    read_addr(2, a);
    check_value("t5_mc_addr2", 32'(a), 32'h0);
    read_cnt(3, c);
    check_value("t5_mc_cnt3", 32'(c), 32'h0);
    read_addr(0, a);
    check_value("t5_mc_addr0", 32'(a), 32'h0);
    program_addr(1, 24'hCCBBAA);
    read_addr(1, a);
    check_value("t5_mc_ptr_zero", 32'(a), 32'hCCBBAA);

    // 6: asynchronous reset mid-cycle while next_word hits a zero count
    channel_select = 4'b0010;
    step(); step();
    check_value("t6_transfer_pre", 32'(transfer_address), 32'hCCBBAA);
    next_word = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check_value("t6_rst_transfer", 32'(transfer_address), 32'h0);
    check_value("t6_rst_tc", 32'(terminal_count), 32'h0);
    check_value("t6_rst_update_high", 32'(update_high_address), 32'h0);
    check_value("t6_rst_data_out", 32'(data_out), 32'h0);
    #2;
    next_word = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("t6_no_tc_after", 32'(terminal_count), 32'h0);
    end
    read_addr(1, a);
    check_value("t6_addr_cleared", 32'(a), 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
